// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Fetch stage that sits in front of the control unit (CU).
//   - Owns the program counter and fetches over a simple req/ack bus.
//   - Captures the returned word in a one-entry buffer. Moves it into the
//     instruction register (IR) when the CU asserts load_ir.
//   - Decodes the IR fields. opcode/f3/f7 go to the CU. rd/rs1/rs2/imm go
//     to the datapath.
//   - Raises stall while the CU wants the IR but the bus has not delivered.
//
// Parameters
//   XLEN      datapath / PC width (>= 32)
//   RESET_PC  PC value after reset
//   TIMEOUT   cycles spent waiting in REQ before fetch_err is raised
//
// Ports
//   clk, rst                 rising-edge clock, async active-low reset
//   en_iaddr                 CU: start an instruction fetch
//   load_ir                  CU: latch the fetched instruction into IR now
//   en_pc_counter            CU: execute stage, PC may advance
//   pc_src_alu               CU: next PC is the ALU result (jal/jalr)
//   branch_taken             datapath: branch condition is true
//   alu_result               datapath: jump target
//   ibus_req/ibus_addr       bus request and address (address = pc)
//   ibus_ack/ibus_rdata      bus response, rdata valid while ack is high
//   stall                    CU: hold the current state
//   pc, next_pc              current PC and pc+4 (link value)
//   opcode,f3,f7,rd,rs1,rs2  raw IR fields
//   imm                      sign-extended immediate selected by opcode
//   fetch_err                sticky: bus timeout or misaligned PC target
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_iaddr,
    input  logic            load_ir,
    input  logic            en_pc_counter,
    input  logic            pc_src_alu,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] alu_result,
    output logic            ibus_req,
    output logic [XLEN-1:0] ibus_addr,
    input  logic            ibus_ack,
    input  logic [31:0]     ibus_rdata,
    output logic            stall,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] next_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      f3,
    output logic [6:0]      f7,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [XLEN-1:0] imm,
    output logic            fetch_err
);

    localparam int          CW  = $clog2(TIMEOUT + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;   // addi x0,x0,0

    // RV32 base opcodes used by the immediate decoder
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q,    pc_d;
    logic [31:0]     ir_q,    ir_d;
    logic [31:0]     buf_q,   buf_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            err_q,   err_d;

    logic [CW-1:0]   cnt_inc;
    logic            stall_c;
    logic            req_ack;
    logic signed [31:0] imm32;

    // Bit 0 of a jump target is always discarded.
    logic unused_alu_lsb;
    assign unused_alu_lsb = alu_result[0];

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= NOP;
            buf_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Fetch FSM, IR/buffer, timeout counter, PC update
    // ------------------------------------------------------------------
    assign req_ack = (state_q == S_REQ) && ibus_ack;

    // The CU can only proceed with load_ir when a word is available, either
    // buffered (HOLD) or arriving this very cycle (bypass).
    assign stall_c = load_ir && !((state_q == S_HOLD) || req_ack);

    // The wait counter saturates, so fetch_err cannot be missed on wrap.
    assign cnt_inc = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                // load_ir with nothing fetched also kicks off a fetch.
                if (en_iaddr || load_ir) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (ibus_ack) begin
                    buf_d = ibus_rdata;
                    cnt_d = '0;
                    if (load_ir) begin
                        ir_d    = ibus_rdata;   // zero-cycle bypass
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_HOLD;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(TIMEOUT)) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (load_ir) begin
                    ir_d    = buf_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // PC advance. The address still updates on a misaligned target,
        // and the error is flagged.
        if (en_pc_counter && !stall_c) begin
            if (pc_src_alu) begin
                pc_d = {alu_result[XLEN-1:1], 1'b0};
            end else if (branch_taken) begin
                pc_d = pc_q + imm;
            end else begin
                pc_d = pc_q + XLEN'(4);
            end
            if (pc_d[1]) begin
                err_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Immediate decode (32-bit form, then sign-extended to XLEN)
    // ------------------------------------------------------------------
    always_comb begin
        imm32 = '0;
        case (ir_q[6:0])
            OP_LOAD, OP_ALUI, OP_JALR:
                imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
            OP_STORE:
                imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            OP_BRANCH:
                imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25],
                         ir_q[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm32 = {ir_q[31:12], 12'b0};
            OP_JAL:
                imm32 = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20],
                         ir_q[30:21], 1'b0};
            default:
                imm32 = '0;   // R-type ALU and unknown opcodes
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imm       = XLEN'(imm32);
    assign ibus_req  = (state_q == S_REQ);   // drops at once on async reset
    assign ibus_addr = pc_q;
    assign stall     = stall_c;
    assign pc        = pc_q;
    assign next_pc   = pc_q + XLEN'(4);
    assign fetch_err = err_q;

    assign opcode = ir_q[6:0];
    assign f3     = ir_q[14:12];
    assign f7     = ir_q[31:25];
    assign rd     = ir_q[11:7];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            en_iaddr = 1'b0, load_ir = 1'b0, en_pc_counter = 1'b0;
    logic            pc_src_alu = 1'b0, branch_taken = 1'b0;
    logic [XLEN-1:0] alu_result = '0;
    logic            ibus_req;
    logic [XLEN-1:0] ibus_addr;
    logic            ibus_ack = 1'b0;
    logic [31:0]     ibus_rdata = '0;
    logic            stall;
    logic [XLEN-1:0] pc, next_pc, imm;
    logic [6:0]      opcode, f7;
    logic [2:0]      f3;
    logic [4:0]      rd, rs1, rs2;
    logic            fetch_err;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] imm;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    // IR as seen through the decoded fields
    logic [31:0] ir_view;
    assign ir_view = {f7, rs2, rs1, f3, rd, opcode};

    instr_fetch #(.XLEN(XLEN), .RESET_PC(32'h0), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .en_iaddr(en_iaddr), .load_ir(load_ir), .en_pc_counter(en_pc_counter),
        .pc_src_alu(pc_src_alu), .branch_taken(branch_taken), .alu_result(alu_result),
        .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_ack(ibus_ack),
        .ibus_rdata(ibus_rdata), .stall(stall), .pc(pc), .next_pc(next_pc),
        .opcode(opcode), .f3(f3), .f7(f7), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        en_iaddr = 0; load_ir = 0; en_pc_counter = 0; pc_src_alu = 0;
        branch_taken = 0; alu_result = '0; ibus_ack = 0; ibus_rdata = '0;
        tick();
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic set_pc(input logic [XLEN-1:0] a);
        en_pc_counter = 1; pc_src_alu = 1; alu_result = a;
        tick();
        en_pc_counter = 0; pc_src_alu = 0; alu_result = '0;
    endtask

    // Full fetch from IDLE: request, ack after 'waits' idle bus cycles, load via HOLD.
    task automatic fetch(input logic [31:0] word, input logic [31:0] exp_imm, input int waits);
        en_iaddr = 1;
        tick();
        en_iaddr = 0;
        repeat (waits) tick();
        ibus_ack = 1; ibus_rdata = word;
        sb.push_back('{ir: word, imm: exp_imm});
        tick();
        ibus_ack = 0; ibus_rdata = '0;
        load_ir = 1;
        tick();
        load_ir = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (ibus_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b exp 0", ibus_req); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b exp 0", stall); end
        tests++; if (fetch_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", fetch_err); end
        tests++; if (pc !== 32'h0) begin fails++; $display("FAIL reset_pc got %h exp 0", pc); end
        tests++; if (ir_view !== 32'h13) begin fails++; $display("FAIL reset_ir got %h exp 00000013", ir_view); end
        tests++; if (next_pc !== 32'h4) begin fails++; $display("FAIL reset_next_pc got %h exp 4", next_pc); end
    endtask

    task automatic test_basic_fetch();
        en_iaddr = 1;
        tick();
        en_iaddr = 0;
        tests++; if (ibus_req !== 1'b1 || ibus_addr !== 32'h0) begin fails++;
            $display("FAIL basic_req got req=%b addr=%h exp req=1 addr=0", ibus_req, ibus_addr); end
        tick();
        tick();
        ibus_ack = 1; ibus_rdata = 32'h0050_0093;
        sb.push_back('{ir: 32'h0050_0093, imm: 32'd5});
        tick();
        ibus_ack = 0;
        tests++; if (ibus_req !== 1'b0) begin fails++; $display("FAIL basic_hold_req got %b exp 0", ibus_req); end
        load_ir = 1;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL basic_load_stall got %b exp 0", stall); end
        tick();
        load_ir = 0;
        tests++; if (sb.size() == 0) begin fails++; $display("FAIL basic_sb got empty exp entry"); end
        else begin
            e = sb.pop_front();
            if (ir_view !== e.ir || imm !== e.imm) begin fails++;
                $display("FAIL basic_ir got ir=%h imm=%h exp ir=%h imm=%h", ir_view, imm, e.ir, e.imm); end
        end
        tests++; if (opcode !== 7'b0010011 || rd !== 5'd1 || imm !== 32'd5) begin fails++;
            $display("FAIL basic_fields got op=%b rd=%0d imm=%h exp 0010011/1/5", opcode, rd, imm); end
    endtask

    task automatic test_load_stall();
        en_iaddr = 1;
        tick();
        en_iaddr = 0;
        load_ir = 1;
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL stall_c1 got %b exp 1", stall); end
        tick();
        tests++; if (stall !== 1'b1 || ir_view !== 32'h0050_0093) begin fails++;
            $display("FAIL stall_c2 got stall=%b ir=%h exp 1/00500093", stall, ir_view); end
        ibus_ack = 1; ibus_rdata = 32'h0000_0033;
        sb.push_back('{ir: 32'h0000_0033, imm: 32'h0});
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL stall_bypass got %b exp 0", stall); end
        tick();
        ibus_ack = 0; load_ir = 0;
        tests++; if (sb.size() == 0) begin fails++; $display("FAIL stall_sb got empty exp entry"); end
        else begin
            e = sb.pop_front();
            if (ir_view !== e.ir || imm !== e.imm) begin fails++;
                $display("FAIL stall_ir got ir=%h imm=%h exp ir=%h imm=%h", ir_view, imm, e.ir, e.imm); end
        end
        tests++; if (ibus_req !== 1'b0) begin fails++; $display("FAIL stall_idle_req got %b exp 0", ibus_req); end
    endtask

    task automatic test_load_idle();
        load_ir = 1;
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL idle_load_stall got %b exp 1", stall); end
        tick();
        tests++; if (ibus_req !== 1'b1 || stall !== 1'b1) begin fails++;
            $display("FAIL idle_load_req got req=%b stall=%b exp 1/1", ibus_req, stall); end
        ibus_ack = 1; ibus_rdata = 32'h0080_00EF;
        sb.push_back('{ir: 32'h0080_00EF, imm: 32'd8});
        tick();
        ibus_ack = 0; load_ir = 0;
        tests++; if (sb.size() == 0) begin fails++; $display("FAIL idle_sb got empty exp entry"); end
        else begin
            e = sb.pop_front();
            if (ir_view !== e.ir || imm !== e.imm) begin fails++;
                $display("FAIL idle_ir got ir=%h imm=%h exp ir=%h imm=%h", ir_view, imm, e.ir, e.imm); end
        end
    endtask

    task automatic test_decode();
        logic [31:0] w [10] = '{32'hFF81_2083, 32'hFE53_2E23, 32'h0053_2623, 32'h1234_51B7,
                               32'hFFFF_F097, 32'hFFDF_F06F, 32'hFFF0_8067, 32'h0020_81B3,
                               32'hFFFF_FFFF, 32'hFE00_0EE3};
        logic [31:0] x [10] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'd12,        32'h1234_5000,
                               32'hFFFF_F000, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0,
                               32'h0,         32'hFFFF_FFFC};
        for (int i = 0; i < 10; i++) begin
            fetch(w[i], x[i], i % 3);
            tests++; if (sb.size() == 0) begin fails++; $display("FAIL decode_sb[%0d] got empty exp entry", i); end
            else begin
                e = sb.pop_front();
                if (ir_view !== e.ir || imm !== e.imm) begin fails++;
                    $display("FAIL decode[%0d] got ir=%h imm=%h exp ir=%h imm=%h", i, ir_view, imm, e.ir, e.imm); end
            end
        end
    endtask

    task automatic test_pc_update();
        do_reset();
        set_pc(32'h100);
        tests++; if (pc !== 32'h100) begin fails++; $display("FAIL pc_set got %h exp 100", pc); end
        fetch(32'hFE00_0EE3, 32'hFFFF_FFFC, 1);
        tests++; if (sb.size() == 0) begin fails++; $display("FAIL pc_sb got empty exp entry"); end
        else begin
            e = sb.pop_front();
            if (ir_view !== e.ir || imm !== e.imm) begin fails++;
                $display("FAIL pc_ir got ir=%h imm=%h exp ir=%h imm=%h", ir_view, imm, e.ir, e.imm); end
        end
        en_pc_counter = 1; branch_taken = 1;
        tick();
        en_pc_counter = 0; branch_taken = 0;
        tests++; if (pc !== 32'hFC) begin fails++; $display("FAIL pc_branch got %h exp fc", pc); end
        set_pc(32'h100);
        en_pc_counter = 1;
        tick();
        en_pc_counter = 0;
        tests++; if (pc !== 32'h104 || fetch_err !== 1'b0) begin fails++;
            $display("FAIL pc_plus4 got pc=%h err=%b exp 104/0", pc, fetch_err); end
        // stalled execute must not move the PC
        load_ir = 1; en_pc_counter = 1;
        tick();
        load_ir = 0; en_pc_counter = 0;
        tests++; if (pc !== 32'h104) begin fails++; $display("FAIL pc_stalled got %h exp 104", pc); end
        ibus_ack = 1; ibus_rdata = 32'hFE00_0EE3; load_ir = 1;
        tick();
        ibus_ack = 0; load_ir = 0;
        pc_src_alu = 1; branch_taken = 1; en_pc_counter = 1; alu_result = 32'h203;
        tick();
        pc_src_alu = 0; branch_taken = 0; en_pc_counter = 0; alu_result = '0;
        tests++; if (pc !== 32'h202 || fetch_err !== 1'b1) begin fails++;
            $display("FAIL pc_alu got pc=%h err=%b exp 202/1", pc, fetch_err); end
        tests++; if (next_pc !== 32'h206) begin fails++; $display("FAIL pc_next got %h exp 206", next_pc); end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        set_pc(32'hFFFF_FFFC);
        tests++; if (next_pc !== 32'h0) begin fails++; $display("FAIL wrap_next got %h exp 0", next_pc); end
        en_pc_counter = 1;
        tick();
        en_pc_counter = 0;
        tests++; if (pc !== 32'h0 || fetch_err !== 1'b0) begin fails++;
            $display("FAIL wrap_pc got pc=%h err=%b exp 0/0", pc, fetch_err); end
    endtask

    task automatic test_timeout();
        do_reset();
        en_iaddr = 1;
        tick();
        en_iaddr = 0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            tests++; if (fetch_err !== 1'b0) begin fails++;
                $display("FAIL timeout_early[%0d] got %b exp 0", k, fetch_err); end
        end
        tick();
        tests++; if (fetch_err !== 1'b1 || ibus_req !== 1'b1) begin fails++;
            $display("FAIL timeout_hit got err=%b req=%b exp 1/1", fetch_err, ibus_req); end
        load_ir = 1;
        #1;
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL timeout_stall got %b exp 1", stall); end
        tick();
        tests++; if (ibus_req !== 1'b1 || stall !== 1'b1) begin fails++;
            $display("FAIL timeout_hold got req=%b stall=%b exp 1/1", ibus_req, stall); end
        ibus_ack = 1; ibus_rdata = 32'h0020_81B3;
        sb.push_back('{ir: 32'h0020_81B3, imm: 32'h0});
        tick();
        ibus_ack = 0; load_ir = 0;
        tests++; if (sb.size() == 0) begin fails++; $display("FAIL timeout_sb got empty exp entry"); end
        else begin
            e = sb.pop_front();
            if (ir_view !== e.ir || imm !== e.imm) begin fails++;
                $display("FAIL timeout_ir got ir=%h imm=%h exp ir=%h imm=%h", ir_view, imm, e.ir, e.imm); end
        end
        tests++; if (fetch_err !== 1'b1) begin fails++; $display("FAIL timeout_sticky got %b exp 1", fetch_err); end
    endtask

    task automatic test_reset_mid_req();
        do_reset();
        set_pc(32'h40);
        fetch(32'h0050_0093, 32'd5, 0);
        tests++; if (sb.size() == 0) begin fails++; $display("FAIL rstmid_sb got empty exp entry"); end
        else begin
            e = sb.pop_front();
            if (ir_view !== e.ir || imm !== e.imm) begin fails++;
                $display("FAIL rstmid_ir got ir=%h imm=%h exp ir=%h imm=%h", ir_view, imm, e.ir, e.imm); end
        end
        en_iaddr = 1;
        tick();
        en_iaddr = 0;
        tests++; if (ibus_req !== 1'b1 || ibus_addr !== 32'h40) begin fails++;
            $display("FAIL rstmid_req got req=%b addr=%h exp 1/40", ibus_req, ibus_addr); end
        #2;
        rst = 1'b0; ibus_ack = 1; ibus_rdata = 32'h0000_0033; load_ir = 1;
        #1;
        tests++; if (ibus_req !== 1'b0) begin fails++; $display("FAIL rstmid_drop got %b exp 0", ibus_req); end
        tick();
        tick();
        rst = 1'b1; ibus_ack = 0; ibus_rdata = '0; load_ir = 0;
        #1;
        tests++; if (pc !== 32'h0 || ir_view !== 32'h13) begin fails++;
            $display("FAIL rstmid_state got pc=%h ir=%h exp 0/00000013", pc, ir_view); end
        tick();
        tests++; if (ibus_req !== 1'b0 || fetch_err !== 1'b0 || ir_view !== 32'h13) begin fails++;
            $display("FAIL rstmid_after got req=%b err=%b ir=%h exp 0/0/00000013", ibus_req, fetch_err, ir_view); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_load_stall();
        test_load_idle();
        test_decode();
        test_pc_update();
        test_pc_wrap();
        test_timeout();
        test_reset_mid_req();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
